// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between byte-stream requesters
//
// Purpose:
//   Grants a single uart_tx to one of num_req_p requesters at a time. Only one
//   character is in flight at a time. With line_lock_p=1 the owner keeps the
//   transmitter until it sends eol_char_p. The grant is also released when the
//   owner hits max_hold_p characters, or sits idle for idle_timeout_p cycles.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   req_v_i      per-requester valid
//   req_data_i   per-requester character, requester i at [i*data_bits_p +: data_bits_p]
//   req_yumi_o   per-requester consume (one-hot or zero)
//   tx_v_o       valid to uart_tx
//   tx_data_o    character to uart_tx
//   tx_yumi_i    uart_tx accepted the character
//   tx_done_i    uart_tx finished the character (1-cycle pulse)
//   busy_o       a grant is active
//   owner_o      current or last owner index

module uart_tx_arbiter #(
    parameter int                     num_req_p      = 4,
    parameter int                     data_bits_p    = 8,
    parameter int                     line_lock_p    = 1,
    parameter logic [data_bits_p-1:0] eol_char_p     = 8'h0A,
    parameter int                     max_hold_p     = 128,
    parameter int                     idle_timeout_p = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    input  logic [num_req_p*data_bits_p-1:0]     req_data_i,
    output logic [num_req_p-1:0]                 req_yumi_o,
    output logic                                 tx_v_o,
    output logic [data_bits_p-1:0]               tx_data_o,
    input  logic                                 tx_yumi_i,
    input  logic                                 tx_done_i,
    output logic                                 busy_o,
    output logic [$clog2(num_req_p)-1:0]         owner_o
);

    localparam int owner_w = $clog2(num_req_p);
    localparam int char_w  = $clog2(max_hold_p + 1);
    localparam int idle_w  = $clog2(idle_timeout_p + 1);

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_wait_done,
        e_locked
    } state_e;

    state_e               r_state;
    logic [owner_w-1:0]   r_owner;
    logic [owner_w-1:0]   r_rr_ptr;
    logic [char_w-1:0]    r_char_cnt;
    logic [idle_w-1:0]    r_idle_cnt;
    logic                 r_eol_seen;

    logic                   w_pick_v;
    logic [owner_w-1:0]     w_pick;
    logic [owner_w-1:0]     w_idx;
    logic [owner_w-1:0]     w_next_ptr;
    logic                   w_owner_v;
    logic [data_bits_p-1:0] w_owner_data;

    // Cyclic scan from r_rr_ptr. Walking offsets from the far end lets the
    // nearest set bit overwrite the others, so it wins.
    always_comb begin
        w_pick_v = 1'b0;
        w_pick   = '0;
        w_idx    = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            w_idx = owner_w'((int'(r_rr_ptr) + k) % num_req_p);
            if (req_v_i[w_idx]) begin
                w_pick_v = 1'b1;
                w_pick   = w_idx;
            end
        end
    end

    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (r_owner == owner_w'(i)) begin
                w_owner_data = req_data_i[i*data_bits_p +: data_bits_p];
            end
        end
    end

    assign w_owner_v  = req_v_i[r_owner];
    // The last owner drops to lowest priority on release.
    assign w_next_ptr = (r_owner == owner_w'(num_req_p - 1)) ? '0 : r_owner + 1'b1;

    assign tx_v_o    = (r_state == e_send) && w_owner_v;
    assign tx_data_o = w_owner_data;
    assign busy_o    = (r_state != e_idle);
    assign owner_o   = r_owner;

    always_comb begin
        req_yumi_o = '0;
        if (r_state == e_send) begin
            req_yumi_o[r_owner] = tx_yumi_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_idle;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_char_cnt <= '0;
            r_idle_cnt <= '0;
            r_eol_seen <= 1'b0;
        end else begin
            case (r_state)
                e_idle: begin
                    if (w_pick_v) begin
                        r_owner    <= w_pick;
                        r_char_cnt <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= e_send;
                    end
                end
                e_send: begin
                    if (tx_yumi_i) begin
                        r_eol_seen <= (w_owner_data == eol_char_p);
                        if (r_char_cnt != char_w'(max_hold_p)) begin
                            r_char_cnt <= r_char_cnt + 1'b1;
                        end
                        r_state <= e_wait_done;
                    end else if (!w_owner_v) begin
                        // Owner retracted its valid: give the transmitter up.
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= e_idle;
                    end
                end
                e_wait_done: begin
                    if (tx_done_i) begin
                        if (line_lock_p == 0 || r_eol_seen ||
                            r_char_cnt == char_w'(max_hold_p)) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= e_idle;
                        end else begin
                            r_idle_cnt <= '0;
                            r_state    <= e_locked;
                        end
                    end
                end
                e_locked: begin
                    if (w_owner_v) begin
                        r_state <= e_send;
                    end else if (r_idle_cnt == idle_w'(idle_timeout_p - 1)) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= e_idle;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

endmodule
